serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller that reuses one 1-bit adder cell (two half adders plus carry OR) across WIDTH cycles.
- Accepts an operand pair over a valid/ready handshake.
- Processes operands LSB-first, one bit per clock, with a registered carry between bits.
- Presents sum and carry-out over a second valid/ready handshake.
- Sits between operand producers and result consumers in arithmetic test designs where adder area is traded for latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands; high only in IDLE.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  subtract request; used only when SERIAL_ADDER_SUB_EN is defined.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  result bits.
out_carry  output  1  final carry-out of the MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_carry=0, busy=0. Internal shift registers, bit counter and carry register are all 0.
- IDLE: when in_valid and in_ready are both high at an edge:
  - latch in_a and in_b into shift registers;
  - clear the carry register (set it to 1 if subtracting, see Optional Feature);
  - clear the bit counter;
  - go to RUN.
- RUN: on each edge, the adder cell takes a_sh[0], b_sh[0] (or its inverse when subtracting) and the carry register.
  - The sum bit shifts into the result register from the MSB side.
  - The carry register takes the cell's carry-out.
  - a_sh and b_sh shift right by 1; the counter increments.
  - On the edge where counter == WIDTH-1, go to DONE and register the final carry into out_carry.
- Latency: out_valid rises exactly WIDTH clock cycles after the accepting edge.
- DONE: out_valid=1. out_sum and out_carry are stable and held while out_ready is low (unbounded backpressure). On an edge with out_ready=1, go to IDLE and clear out_valid. out_sum keeps its last value until the next DONE.
- No overlap: in_ready is 0 in RUN and DONE, so in_valid is ignored there. At least one IDLE cycle separates consecutive results.
- in_valid and in_a/in_b may change freely while in_ready=0. No stability is required before acceptance.
- Reset mid-RUN or mid-DONE: the operation is aborted and everything returns to reset values on that edge. No partial result is emitted.
- Counter width is $clog2(WIDTH)+1, which is safe for WIDTH=1. With WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^WIDTH. out_carry is the true carry-out (1 = unsigned overflow on add).

Optional Feature:
SERIAL_ADDER_SUB_EN.
- Defined:
  - in_sub is latched at acceptance.
  - If in_sub=1, each b bit is inverted before the adder cell and the carry register is seeded with 1. The result is A-B mod 2^WIDTH.
  - out_carry=1 means no borrow (A>=B); out_carry=0 means borrow.
- Undefined: in_sub is ignored, the carry seed is always 0, the block only adds, and the port remains present.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum typedef with IDLE, RUN, DONE;
  - localparam for the default WIDTH;
  - counter-width function.
- Sub-module adder_bit_cell: combinational 1-bit full adder built from two half-adder equations (a, b, cin -> s, cout). It is instantiated once; the controller owns all sequencing.

Test Plan:
All scenarios use WIDTH=8.
- 0x0F + 0x01 -> out_sum=0x10, out_carry=0; out_valid rises 8 cycles after the accept edge; in_ready low throughout.
- 0xFF + 0x01 -> out_sum=0x00, out_carry=1. Then 0x00 + 0x00 -> out_sum=0x00, out_carry=0, which confirms the carry register is cleared between operations.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE with 0xA5 + 0x5A;
  - out_sum=0xFF and out_carry=0 stay stable, and out_valid stays high;
  - in_valid pulsed during DONE is ignored;
  - release out_ready -> IDLE next edge.
- Reset mid-operation: assert rst on the 3rd RUN cycle of 0x12 + 0x34 -> next edge gives state IDLE, in_ready=1, out_valid=0, out_sum=0. A fresh 0x12 + 0x34 then yields 0x46.
- SERIAL_ADDER_SUB_EN defined:
  - 0x05 - 0x07 (in_sub=1) -> out_sum=0xFE, out_carry=0;
  - 0x07 - 0x05 -> out_sum=0x02, out_carry=1.
  - Macro undefined, same stimulus with in_sub=1 -> 0x05 + 0x07 = 0x0C, out_carry=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t          : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH    : default operand / sum width in bits
//   cntWidth()       : width of the bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // One extra bit over $clog2 so that WIDTH=1 still yields a 1-bit counter
    // ($clog2(1) is 0).
    function automatic int cntWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder_bit_cell.sv
// ----------------------------------------------------------------------------
// adder_bit_cell
// Combinational 1-bit full adder built from two half adders and a carry OR.
//   i_a, i_b  : operand bits
//   i_cin     : carry in
//   o_s       : sum bit
//   o_cout    : carry out
// ----------------------------------------------------------------------------
module adder_bit_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder on the operand bits, second half adder folds in the
    // carry; either half adder may generate the outgoing carry.
    assign w_s1   = i_a ^ i_b;
    assign w_c1   = i_a & i_b;
    assign o_s    = w_s1 ^ i_cin;
    assign w_c2   = w_s1 & i_cin;
    assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder: one adder_bit_cell reused over WIDTH clocks,
// operands processed LSB first with a registered carry between bits.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   in_a, in_b            : operands
//   in_sub                : subtract request (honoured only with the
//                           SERIAL_ADDER_SUB_EN macro defined)
//   out_valid / out_ready : result handshake (valid only in DONE)
//   out_sum, out_carry    : result and final carry-out
//   busy                  : high in RUN or DONE
// Build option: define SERIAL_ADDER_SUB_EN to enable A-B via in_sub.
// ----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int CW = cntWidth(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_outSum;
    logic             r_outCarry;
    logic             r_carry;
    logic             r_sub;
    logic [CW-1:0]    r_cnt;

    logic             w_subReq;
    logic             w_accept;
    logic             w_lastBit;
    logic             w_bIn;
    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sumNext;

    // Subtraction only exists in builds that ask for it; otherwise the port
    // stays present but its value is masked off.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_subReq = in_sub;
`else
    assign w_subReq = in_sub & 1'b0;
`endif

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_lastBit = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

    // Two's-complement subtract: invert B and seed the carry with 1.
    assign w_bIn = r_bSh[0] ^ r_sub;

    adder_bit_cell u_cell (
        .i_a    (r_aSh[0]),
        .i_b    (w_bIn),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the first bit has
    // reached bit 0. Written as a shift so it also holds for WIDTH=1.
    assign w_sumNext = (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH bit steps in RUN, hold in DONE
    // until the consumer takes the result.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_lastBit) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand/result shift registers, carry and bit counter. The
    // published result is a separate register so out_sum only changes when
    // a new result completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aSh      <= '0;
            r_bSh      <= '0;
            r_sum      <= '0;
            r_outSum   <= '0;
            r_outCarry <= 1'b0;
            r_carry    <= 1'b0;
            r_sub      <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_aSh   <= in_a;
            r_bSh   <= in_b;
            r_sub   <= w_subReq;
            r_carry <= w_subReq;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_aSh   <= r_aSh >> 1;
            r_bSh   <= r_bSh >> 1;
            r_sum   <= w_sumNext;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_outSum   <= w_sumNext;
                r_outCarry <= w_cout;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_outSum;
    assign out_carry = r_outCarry;

endmodule
